// File: rtl/uart_imem_loader.sv
// rtl/uart_imem_loader.sv - boot loader: UART bytes to 32-bit instruction-memory writes, core held in reset until sentinel
// Optional running sum of written words enabled by defining LOADER_CHECKSUM_EN.
module uart_imem_loader #(
  parameter int ADDR_W      = 8,
  parameter int MAX_WORDS   = 256,
  parameter int TIMEOUT_CYC = 52080
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              uart_rx_valid,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_break,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              write_done,
  output logic              cpu_rst,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow_err,
  output logic [31:0]       load_checksum
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_WRITE,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [23:0]        shift_q, shift_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
  logic [31:0]        imem_wdata_q, imem_wdata_d;
  logic [ADDR_W:0]    word_count_q, word_count_d;
  logic               overflow_err_q, overflow_err_d;

  logic               timeout_hit;
  logic [1:0]         eff_idx;
  logic [31:0]        full_word;
  logic               mem_full;

  always_comb begin
    state_d        = state_q;
    byte_idx_d     = byte_idx_q;
    shift_d        = shift_q;
    idle_cnt_d     = idle_cnt_q;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    word_count_d   = word_count_q;
    overflow_err_d = overflow_err_q;

    timeout_hit = (byte_idx_q != 2'd0) && (idle_cnt_q == CNT_W'(TIMEOUT_CYC));
    eff_idx     = timeout_hit ? 2'd0 : byte_idx_q;
    full_word   = {uart_rx_data, shift_q};
    mem_full    = (word_count_q == (ADDR_W + 1)'(MAX_WORDS));

    // Idle counter only runs while a word is partially assembled.
    if (byte_idx_q == 2'd0 || timeout_hit) begin
      idle_cnt_d = '0;
    end else begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
    if (timeout_hit) begin
      byte_idx_d = 2'd0;
    end

    case (state_q)
      ST_WRITE: begin
        if (!mem_full) begin
          word_count_d = word_count_q + 1'b1;
        end
        state_d = ST_COLLECT;
      end
      default: ;
    endcase

    // Byte collection also runs in WRITE so a byte landing there starts the next word.
    if (state_q != ST_DONE) begin
      if (uart_rx_break) begin
        byte_idx_d = 2'd0;
        idle_cnt_d = '0;
      end else if (uart_rx_valid) begin
        idle_cnt_d = '0;
        if (eff_idx == 2'd3) begin
          byte_idx_d = 2'd0;
          if (full_word == 32'hFFFF_FFFF) begin
            state_d = ST_DONE;
          end else if (mem_full) begin
            overflow_err_d = 1'b1;
            state_d        = ST_DONE;
          end else begin
            state_d      = ST_WRITE;
            imem_addr_d  = word_count_q[ADDR_W-1:0];
            imem_wdata_d = full_word;
          end
        end else begin
          shift_d[{eff_idx, 3'b000} +: 8] = uart_rx_data;
          byte_idx_d = eff_idx + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_COLLECT;
      byte_idx_q     <= 2'd0;
      shift_q        <= '0;
      idle_cnt_q     <= '0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      word_count_q   <= '0;
      overflow_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_idx_q     <= byte_idx_d;
      shift_q        <= shift_d;
      idle_cnt_q     <= idle_cnt_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      word_count_q   <= word_count_d;
      overflow_err_q <= overflow_err_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (state_q == ST_WRITE) begin
      checksum_d = checksum_q + imem_wdata_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign load_checksum = checksum_q;
`else
  assign load_checksum = 32'd0;
`endif

  assign imem_we      = (state_q == ST_WRITE);
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign write_done   = (state_q == ST_DONE);
  assign cpu_rst      = (state_q != ST_DONE);
  assign word_count   = word_count_q;
  assign overflow_err = overflow_err_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// tb/tb_uart_imem_loader.sv - directed self-checking bench for uart_imem_loader
module tb_uart_imem_loader;

  localparam int ADDR_W      = 8;
  localparam int MAX_WORDS   = 4;
  localparam int TIMEOUT_CYC = 40;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              uart_rx_valid = 1'b0;
  logic [7:0]        uart_rx_data = 8'h00;
  logic              uart_rx_break = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              write_done;
  logic              cpu_rst;
  logic [ADDR_W:0]   word_count;
  logic              overflow_err;
  logic [31:0]       load_checksum;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] exp_sum;

  uart_imem_loader #(
    .ADDR_W(ADDR_W),
    .MAX_WORDS(MAX_WORDS),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_data(uart_rx_data),
    .uart_rx_break(uart_rx_break),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .write_done(write_done),
    .cpu_rst(cpu_rst),
    .word_count(word_count),
    .overflow_err(overflow_err),
    .load_checksum(load_checksum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resetn && imem_we) begin
      wr_addr.push_back(32'(imem_addr));
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    @(posedge clk);
    #1;
    uart_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic do_reset();
    uart_rx_valid = 1'b0;
    uart_rx_break = 1'b0;
    resetn = 1'b0;
    idle(2);
    wr_addr.delete();
    wr_data.delete();
    resetn = 1'b1;
    idle(1);
  endtask

  initial begin
    // Reset state
    resetn = 1'b0;
    idle(2);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_done", 32'(write_done), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_count", 32'(word_count), 32'd0);
    check("rst_ovf", 32'(overflow_err), 32'd0);
    check("rst_csum", load_checksum, 32'd0);

    // Two words plus sentinel
    do_reset();
    send_word(32'hfe010113);
    send_word(32'h00812e23);
    send_byte(8'hff);
    send_byte(8'hff);
    send_byte(8'hff);
    check("t1_done_before", 32'(write_done), 32'd0);
    check("t1_cpurst_before", 32'(cpu_rst), 32'd1);
    send_byte(8'hff);
    check("t1_done", 32'(write_done), 32'd1);
    check("t1_cpurst", 32'(cpu_rst), 32'd0);
    check("t1_nwr", 32'(wr_data.size()), 32'd2);
    check("t1_a0", wr_addr[0], 32'd0);
    check("t1_d0", wr_data[0], 32'hfe010113);
    check("t1_a1", wr_addr[1], 32'd1);
    check("t1_d1", wr_data[1], 32'h00812e23);
    check("t1_count", 32'(word_count), 32'd2);
`ifdef LOADER_CHECKSUM_EN
    exp_sum = 32'hfe010113 + 32'h00812e23;
`else
    exp_sum = 32'd0;
`endif
    check("t1_csum", load_checksum, exp_sum);
    send_word(32'h12345678);
    idle(3);
    check("t1_ignored_nwr", 32'(wr_data.size()), 32'd2);
    check("t1_ignored_count", 32'(word_count), 32'd2);
    check("t1_still_done", 32'(write_done), 32'd1);

    // Break discards partial word; break with valid drops the byte
    do_reset();
    send_byte(8'h13);
    send_byte(8'h01);
    uart_rx_break = 1'b1;
    idle(1);
    uart_rx_break = 1'b0;
    send_word(32'h00812e23);
    idle(2);
    check("t2_nwr", 32'(wr_data.size()), 32'd1);
    check("t2_a0", wr_addr[0], 32'd0);
    check("t2_d0", wr_data[0], 32'h00812e23);
    send_byte(8'h99);
    uart_rx_break = 1'b1;
    send_byte(8'h55);
    uart_rx_break = 1'b0;
    send_word(32'hcafe0042);
    idle(2);
    check("t2_brk_valid_nwr", 32'(wr_data.size()), 32'd2);
    check("t2_brk_valid_a", wr_addr[1], 32'd1);
    check("t2_brk_valid_d", wr_data[1], 32'hcafe0042);
    check("t2_done", 32'(write_done), 32'd0);

    // Idle timeout resyncs a stale partial byte
    do_reset();
    send_byte(8'h13);
    idle(TIMEOUT_CYC + 10);
    send_word(32'h00000013);
    idle(2);
    check("t3_nwr", 32'(wr_data.size()), 32'd1);
    check("t3_a0", wr_addr[0], 32'd0);
    check("t3_d0", wr_data[0], 32'h00000013);

    // Overflow with MAX_WORDS=4
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_word(32'h10000000 + 32'(i));
      idle(1);
    end
    idle(2);
    check("t4_nwr", 32'(wr_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_a%0d", i), wr_addr[i], 32'(i));
      check($sformatf("t4_d%0d", i), wr_data[i], 32'h10000000 + 32'(i));
    end
    check("t4_ovf", 32'(overflow_err), 32'd1);
    check("t4_done", 32'(write_done), 32'd1);
    check("t4_count", 32'(word_count), 32'd4);
    check("t4_cpurst", 32'(cpu_rst), 32'd0);

    // Byte arriving in the WRITE cycle
    do_reset();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    check("t5_we_in_write", 32'(imem_we), 32'd1);
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    idle(3);
    check("t5_nwr", 32'(wr_data.size()), 32'd2);
    check("t5_a0", wr_addr[0], 32'd0);
    check("t5_d0", wr_data[0], 32'h44332211);
    check("t5_a1", wr_addr[1], 32'd1);
    check("t5_d1", wr_data[1], 32'h88776655);
    check("t5_hold_we", 32'(imem_we), 32'd0);
    check("t5_hold_addr", 32'(imem_addr), 32'd1);
    check("t5_hold_data", imem_wdata, 32'h88776655);

    // Reset mid-load restarts at address 0
    do_reset();
    send_word(32'h01010101);
    send_word(32'h02020202);
    idle(2);
    check("t6_pre_nwr", 32'(wr_data.size()), 32'd2);
    check("t6_pre_done", 32'(write_done), 32'd0);
    check("t6_pre_cpurst", 32'(cpu_rst), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_async_count", 32'(word_count), 32'd0);
    check("t6_async_done", 32'(write_done), 32'd0);
    check("t6_async_cpurst", 32'(cpu_rst), 32'd1);
    idle(2);
    wr_addr.delete();
    wr_data.delete();
    resetn = 1'b1;
    idle(1);
    send_word(32'haaaa0001);
    send_word(32'hbbbb0002);
    send_byte(8'hff);
    send_byte(8'hff);
    send_byte(8'hff);
    check("t6_cpurst_hold", 32'(cpu_rst), 32'd1);
    check("t6_done_low", 32'(write_done), 32'd0);
    send_byte(8'hff);
    check("t6_done", 32'(write_done), 32'd1);
    check("t6_nwr", 32'(wr_data.size()), 32'd2);
    check("t6_a0", wr_addr[0], 32'd0);
    check("t6_d0", wr_data[0], 32'haaaa0001);
    check("t6_a1", wr_addr[1], 32'd1);
    check("t6_d1", wr_data[1], 32'hbbbb0002);
    check("t6_count", 32'(word_count), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
